// File: rtl/gain_stage_if.sv
// Sample/volume bus of the audio gain stage: upstream show-ahead FIFO read side,
// downstream FIFO write side and the volume load port.
interface gain_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] din;
  logic                         in_empty;
  logic                         in_rd_en;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         out_full;
  logic                         out_wr_en;
  logic signed [DATA_WIDTH-1:0] volume;
  logic                         volume_wr;

  modport master (
    output din, in_empty, out_full, volume, volume_wr,
    input  in_rd_en, dout, out_wr_en
  );

  modport slave (
    input  din, in_empty, out_full, volume, volume_wr,
    output in_rd_en, dout, out_wr_en
  );
endinterface

// File: rtl/gain_stage.sv
// Audio gain stage: sample * volume, dequantize toward zero, shift, fit to DATA_WIDTH.
// Define GAIN_SAT_EN to clamp instead of wrap and to get the sticky sat_flag.
module gain_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int QBITS          = 10,
  parameter int OUT_SHIFT      = 0,
  parameter int DEFAULT_VOLUME = 1024
) (
  input  logic         clock,
  input  logic         reset,
  gain_stage_if.slave  bus
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] ROUND_BIAS = (PW'(1) <<< QBITS) - PW'(1);

  typedef enum logic [1:0] {S_READ, S_MULT, S_SCALE, S_WRITE} state_t;

  state_t                       state;
  state_t                       state_next;
  logic signed [DATA_WIDTH-1:0] x_reg;
  logic signed [DATA_WIDTH-1:0] vol_reg;
  logic signed [DATA_WIDTH-1:0] vol_pend;
  logic                         pend_valid;
  logic signed [DATA_WIDTH-1:0] dout_reg;
  logic signed [DATA_WIDTH-1:0] fit_val;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         bias;
  logic signed [PW-1:0]         q_val;
  logic signed [PW-1:0]         s_val;
  logic                         rd_en;
  logic                         wr_en;
`ifdef GAIN_SAT_EN
  logic                         clip;
  logic                         sat_flag;
`endif

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    case (state)
      S_READ: begin
        if (!bus.in_empty && !reset) begin
          rd_en      = 1'b1;
          state_next = S_MULT;
        end
      end
      S_MULT:  state_next = S_SCALE;
      S_SCALE: state_next = S_WRITE;
      S_WRITE: begin
        if (!bus.out_full && !reset) begin
          wr_en      = 1'b1;
          state_next = S_READ;
        end
      end
      default: state_next = S_READ;
    endcase
  end

  // Biasing negative products before the arithmetic shift makes it truncate toward zero.
  always_comb begin
    bias = '0;
    if (prod[PW-1]) bias = ROUND_BIAS;
    q_val = $signed(prod + bias) >>> QBITS;
    s_val = q_val <<< OUT_SHIFT;
`ifdef GAIN_SAT_EN
    clip = (s_val[PW-1:DATA_WIDTH-1] != {(PW-DATA_WIDTH+1){s_val[PW-1]}});
    if (clip)
      fit_val = s_val[PW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      fit_val = s_val[DATA_WIDTH-1:0];
`else
    fit_val = s_val[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_READ;
      x_reg      <= '0;
      vol_reg    <= DATA_WIDTH'(DEFAULT_VOLUME);
      vol_pend   <= '0;
      pend_valid <= 1'b0;
      prod       <= '0;
      dout_reg   <= '0;
`ifdef GAIN_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (bus.volume_wr && !rd_en) begin
        vol_pend   <= bus.volume;
        pend_valid <= 1'b1;
      end
      // A write landing on the pop cycle takes effect for that very sample.
      if (rd_en) begin
        x_reg      <= bus.din;
        pend_valid <= 1'b0;
        if (bus.volume_wr)
          vol_reg <= bus.volume;
        else if (pend_valid)
          vol_reg <= vol_pend;
      end
      if (state == S_MULT)
        prod <= PW'(x_reg) * PW'(vol_reg);
      if (state == S_SCALE) begin
        dout_reg <= fit_val;
`ifdef GAIN_SAT_EN
        if (clip) sat_flag <= 1'b1;
`endif
      end
    end
  end

  assign bus.in_rd_en  = rd_en;
  assign bus.out_wr_en = wr_en;
  assign bus.dout      = dout_reg;
endmodule

// File: tb/tb_gain_stage.sv
// Self-checking bench for gain_stage: vector table, multi-cycle corner sequences,
// and randomized samples compared against a plain-arithmetic reference model.
module tb_gain_stage;
  localparam int DW        = 32;
  localparam int QBITS     = 10;
  localparam int OUT_SHIFT = 0;

  typedef struct {
    int          vol;
    int          din;
    logic [31:0] exp;
  } vec_t;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  gain_stage_if #(.DATA_WIDTH(DW)) bus ();

  gain_stage #(
    .DATA_WIDTH(DW), .QBITS(QBITS), .OUT_SHIFT(OUT_SHIFT), .DEFAULT_VOLUME(1024)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: exact integer product, C-style division (toward zero), shift, then fit.
  function automatic logic [31:0] model(input int x, input int v);
    longint p;
    longint q;
    p = longint'(x) * longint'(v);
    q = p / (longint'(1) <<< QBITS);
    q = q <<< OUT_SHIFT;
`ifdef GAIN_SAT_EN
    if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (q < -64'sd2147483648) return 32'h8000_0000;
`endif
    return q[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int vol, input bit write_vol, input int sample,
                               output logic [31:0] result, output int latency);
    bit got;
    result  = '0;
    latency = -1;
    @(negedge clock);
    if (write_vol) begin
      bus.volume    = vol;
      bus.volume_wr = 1'b1;
      @(negedge clock);
      bus.volume_wr = 1'b0;
    end
    bus.din      = sample;
    bus.in_empty = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (bus.in_rd_en) got = 1'b1;
      else @(negedge clock);
    end
    if (!got) begin
      checkOutput("pop_seen", 32'(got), 32'd1);
      bus.in_empty = 1'b1;
      return;
    end
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clock);
      bus.in_empty = 1'b1;
      #1;
      if (bus.out_wr_en) begin
        got     = 1'b1;
        result  = bus.dout;
        latency = k;
      end
    end
    if (!got) checkOutput("push_seen", 32'(got), 32'd1);
  endtask

  initial begin
    vec_t        vecs[11];
    logic [31:0] res;
    logic [31:0] outq[$];
    int          lat;
    int          pops;
    int          pushes;
    int          wr_at;
    int          empty_at;
    int          cur_vol;
    int          rv;
    int          rx;
    bit          got;

    vecs[0]  = '{1024, 1000, 32'd1000};
    vecs[1]  = '{512, -3, 32'hFFFF_FFFF};
    vecs[2]  = '{512, 3, 32'd1};
`ifdef GAIN_SAT_EN
    vecs[3]  = '{4096, 32'h4000_0000, 32'h7FFF_FFFF};
    vecs[9]  = '{-4096, 32'h4000_0000, 32'h8000_0000};
`else
    vecs[3]  = '{4096, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{-4096, 32'h4000_0000, 32'h0000_0000};
`endif
    vecs[4]  = '{1024, -1000, 32'hFFFF_FC18};
    vecs[5]  = '{1536, -1, 32'hFFFF_FFFF};
    vecs[6]  = '{1, 1023, 32'd0};
    vecs[7]  = '{-1024, 5, 32'hFFFF_FFFB};
    vecs[8]  = '{1024, 32'h8000_0000, 32'h8000_0000};
    vecs[10] = '{3, -341, 32'd0};

    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.din       = 32'd123;
    bus.in_empty  = 1'b0;
    bus.out_full  = 1'b0;
    bus.volume    = '0;
    bus.volume_wr = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_rd_en", 32'(bus.in_rd_en), 32'd0);
    checkOutput("reset_wr_en", 32'(bus.out_wr_en), 32'd0);
    checkOutput("reset_dout", bus.dout, 32'd0);
`ifdef GAIN_SAT_EN
    checkOutput("reset_sat_flag", 32'(dut.sat_flag), 32'd0);
`endif
    bus.in_empty = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // Default volume is unity with no write at all.
    applyStimulus(0, 1'b0, 1000, res, lat);
    checkOutput("default_vol", res, 32'd1000);
    checkOutput("latency", 32'(lat), 32'd3);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].vol, 1'b1, vecs[i].din, res, lat);
      checkOutput($sformatf("vec%0d", i), res, vecs[i].exp);
`ifdef GAIN_SAT_EN
      if (i == 3) checkOutput("sat_flag", 32'(dut.sat_flag), 32'd1);
`endif
    end

    // Backpressure: stall in S_WRITE with another sample waiting upstream.
    @(negedge clock);
    bus.out_full  = 1'b1;
    bus.volume    = 1024;
    bus.volume_wr = 1'b1;
    @(negedge clock);
    bus.volume_wr = 1'b0;
    bus.din       = 77;
    bus.in_empty  = 1'b0;
    #1;
    checkOutput("bp_pop", 32'(bus.in_rd_en), 32'd1);
    @(negedge clock);
    bus.din = 88;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("bp_no_rd", {30'd0, bus.in_rd_en, bus.out_wr_en}, 32'd0);
      checkOutput("bp_dout", bus.dout, 32'd77);
      @(negedge clock);
    end
    bus.out_full = 1'b0;
    bus.in_empty = 1'b1;
    #1;
    checkOutput("bp_release_wr", 32'(bus.out_wr_en), 32'd1);
    checkOutput("bp_release_dout", bus.dout, 32'd77);
    pushes = 0;
    repeat (6) begin
      @(negedge clock);
      #1;
      if (bus.out_wr_en) pushes++;
    end
    checkOutput("bp_extra_push", 32'(pushes), 32'd0);

    // Volume timing: write 2048 during the second sample's multiply cycle.
    @(negedge clock);
    bus.din      = 100;
    bus.volume   = 2048;
    pops         = 0;
    wr_at        = -1;
    empty_at     = 1000;
    outq.delete();
    for (int cyc = 0; cyc < 80 && outq.size() < 4; cyc++) begin
      bus.volume_wr = (cyc == wr_at);
      bus.in_empty  = (cyc >= empty_at);
      #1;
      if (bus.in_rd_en) begin
        pops++;
        if (pops == 2) wr_at = cyc + 1;
        if (pops == 4) empty_at = cyc + 1;
      end
      if (bus.out_wr_en) outq.push_back(bus.dout);
      @(negedge clock);
    end
    bus.volume_wr = 1'b0;
    bus.in_empty  = 1'b1;
    checkOutput("vt_count", 32'(outq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < outq.size())
        checkOutput($sformatf("vt_out%0d", i), outq[i], (i < 2) ? 32'd100 : 32'd200);
    end

    // Reset in S_SCALE, with a pending volume that must be discarded.
    @(negedge clock);
    bus.din      = 50;
    bus.in_empty = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (bus.in_rd_en) got = 1'b1;
      else @(negedge clock);
    end
    checkOutput("rst_pop", 32'(got), 32'd1);
    @(negedge clock);
    bus.in_empty  = 1'b1;
    bus.volume    = 3072;
    bus.volume_wr = 1'b1;
    @(negedge clock);
    bus.volume_wr = 1'b0;
    reset         = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst_dout", bus.dout, 32'd0);
    pushes = 0;
    repeat (6) begin
      if (bus.out_wr_en) pushes++;
      @(negedge clock);
      #1;
    end
    checkOutput("rst_no_push", 32'(pushes), 32'd0);
    applyStimulus(0, 1'b0, 7, res, lat);
    checkOutput("rst_next_sample", res, 32'd7);

    cur_vol = 1024;
    for (int i = 0; i < 40; i++) begin
      got = ($urandom_range(0, 1) == 1);
      rv  = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 8192)) - 4096;
      rx  = ($urandom_range(0, 1) == 0) ? int'($urandom) : int'($urandom_range(0, 200000)) - 100000;
      if (got) cur_vol = rv;
      applyStimulus(rv, got, rx, res, lat);
      checkOutput($sformatf("rand%0d", i), res, model(rx, cur_vol));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
